// File: rtl/stream_pingpong_buffer_if.sv
// Stream-in / AXI-Lite bundle for the ping-pong frame buffer.
// "slave" is the buffer side; "master" is the producer/host side.
interface stream_pingpong_buffer_if #(
    parameter int DATA_WIDTH      = 16,
    parameter int AXIL_ADDR_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]      s_axis_tdata;
    logic                       s_axis_tvalid;
    logic                       s_axis_tready;
    logic                       s_axis_tuser;
    logic                       s_axis_tlast;

    logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr;
    logic                       s_axil_awvalid;
    logic                       s_axil_awready;
    logic [31:0]                s_axil_wdata;
    logic [3:0]                 s_axil_wstrb;
    logic                       s_axil_wvalid;
    logic                       s_axil_wready;
    logic [1:0]                 s_axil_bresp;
    logic                       s_axil_bvalid;
    logic                       s_axil_bready;
    logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr;
    logic                       s_axil_arvalid;
    logic                       s_axil_arready;
    logic [31:0]                s_axil_rdata;
    logic [1:0]                 s_axil_rresp;
    logic                       s_axil_rvalid;
    logic                       s_axil_rready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tuser, s_axis_tlast,
        output s_axis_tready,
        input  s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
        output s_axil_awready, s_axil_wready,
        output s_axil_bresp, s_axil_bvalid,
        input  s_axil_bready,
        input  s_axil_araddr, s_axil_arvalid,
        output s_axil_arready,
        output s_axil_rdata, s_axil_rresp, s_axil_rvalid,
        input  s_axil_rready
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tuser, s_axis_tlast,
        input  s_axis_tready,
        output s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
        input  s_axil_awready, s_axil_wready,
        input  s_axil_bresp, s_axil_bvalid,
        output s_axil_bready,
        output s_axil_araddr, s_axil_arvalid,
        input  s_axil_arready,
        input  s_axil_rdata, s_axil_rresp, s_axil_rvalid,
        output s_axil_rready
    );
endinterface

// File: rtl/stream_pingpong_buffer.sv
// Double-buffered frame capture: the stream fills one bank while the host reads
// the other over AXI-Lite; banks swap when a frame completes and the host has released.
module stream_pingpong_buffer #(
    parameter int DATA_WIDTH      = 16,
    parameter int DEPTH           = 1024,
    parameter int AXIL_ADDR_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ce,
    stream_pingpong_buffer_if.slave  bus,
    output logic                     irq
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int AW    = AXIL_ADDR_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SOF     = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    logic [1:0]            state;
    logic [IDX_W-1:0]      idx;
    logic                  wbank;
    logic                  rbank;
    logic                  ctrl_enable;
    logic                  ctrl_irq_en;
    logic                  frame_ready;
    logic                  overflow;
    logic [IDX_W:0]        frame_len;
    logic [15:0]           drop_cnt;
    logic [DATA_WIDTH-1:0] mem [2*DEPTH];
    logic [DATA_WIDTH-1:0] mem_q;

    assign rbank = ~wbank;

    // Stream side: a tuser beat always lands at index 0, both from SOF and as a restart in WRITE.
    logic             beat;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic             frame_done;
    logic             truncated;
    logic [IDX_W:0]   done_len;

    assign bus.s_axis_tready = ce && ctrl_enable && (state != ST_IDLE);
    assign beat       = bus.s_axis_tvalid && bus.s_axis_tready;
    assign wr_en      = beat && ((state == ST_SOF && bus.s_axis_tuser) || state == ST_WRITE);
    assign wr_idx     = bus.s_axis_tuser ? '0 : idx;
    assign frame_done = wr_en && (bus.s_axis_tlast || wr_idx == LAST_IDX);
    assign truncated  = wr_en && !bus.s_axis_tlast && wr_idx == LAST_IDX;
    assign done_len   = (IDX_W+1)'(wr_idx) + (IDX_W+1)'(1);

    // AXI-Lite write decode; address and data are accepted together.
    logic aw_hs;
    logic wr_reg;
    logic wr_ctrl;
    logic wr_status;
    logic release_pulse;
    logic ready_after_release;

    assign aw_hs = bus.s_axil_awvalid && bus.s_axil_wvalid && !bus.s_axil_bvalid;
    assign bus.s_axil_awready = aw_hs;
    assign bus.s_axil_wready  = aw_hs;
    assign bus.s_axil_bresp   = 2'b00;
    assign wr_reg    = aw_hs && !bus.s_axil_awaddr[AW-1] && ~|bus.s_axil_awaddr[AW-2:4];
    assign wr_ctrl   = wr_reg && bus.s_axil_awaddr[3:2] == 2'd0;
    assign wr_status = wr_reg && bus.s_axil_awaddr[3:2] == 2'd1;
    assign release_pulse       = wr_ctrl && bus.s_axil_wdata[2];
    assign ready_after_release = frame_ready && !release_pulse;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else if (ce) begin
            if (!ctrl_enable) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_SOF;
                    ST_SOF, ST_WRITE: begin
                        if (wr_en) begin
                            idx   <= wr_idx + IDX_W'(1);
                            state <= truncated ? ST_DISCARD : (frame_done ? ST_SOF : ST_WRITE);
                        end
                    end
                    ST_DISCARD: if (beat && bus.s_axis_tlast) state <= ST_SOF;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Release is applied before completion so a same-cycle completion still swaps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wbank         <= 1'b0;
            ctrl_enable   <= 1'b0;
            ctrl_irq_en   <= 1'b0;
            frame_ready   <= 1'b0;
            overflow      <= 1'b0;
            frame_len     <= '0;
            drop_cnt      <= '0;
            bus.s_axil_bvalid <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_enable <= bus.s_axil_wdata[0];
                ctrl_irq_en <= bus.s_axil_wdata[1];
            end
            frame_ready <= ready_after_release;
            if (frame_done) begin
                if (!ready_after_release) begin
                    wbank       <= ~wbank;
                    frame_len   <= done_len;
                    frame_ready <= 1'b1;
                end else if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
            if (truncated)
                overflow <= 1'b1;
            else if (wr_status && bus.s_axil_wdata[1])
                overflow <= 1'b0;
            if (aw_hs)
                bus.s_axil_bvalid <= 1'b1;
            else if (bus.s_axil_bready)
                bus.s_axil_bvalid <= 1'b0;
        end
    end

    assign irq = frame_ready && ctrl_irq_en;

    // AXI-Lite read: registers are muxed at the handshake, sample data comes from the RAM port.
    logic        ar_hs;
    logic        rd_sel_data;
    logic [31:0] rd_reg_q;
    logic [31:0] reg_rdata;

    // Gated by reset so arready is low while reset is held.
    assign bus.s_axil_arready = reset_n && !bus.s_axil_rvalid;
    assign ar_hs = bus.s_axil_arvalid && bus.s_axil_arready;
    assign bus.s_axil_rresp = 2'b00;

    // NOTE: always_comb gives every output a default first, so no path can infer a latch.
    always_comb begin
        reg_rdata = 32'd0;
        if (!bus.s_axil_araddr[AW-1] && ~|bus.s_axil_araddr[AW-2:4]) begin
            case (bus.s_axil_araddr[3:2])
                2'd0: reg_rdata = {30'd0, ctrl_irq_en, ctrl_enable};
                2'd1: reg_rdata = {29'd0, state == ST_WRITE, overflow, frame_ready};
                2'd2: reg_rdata = 32'(frame_len);
                2'd3: reg_rdata = {16'd0, drop_cnt};
                default: reg_rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.s_axil_rvalid <= 1'b0;
            rd_sel_data       <= 1'b0;
            rd_reg_q          <= '0;
        end else if (ar_hs) begin
            bus.s_axil_rvalid <= 1'b1;
            rd_sel_data       <= bus.s_axil_araddr[AW-1];
            rd_reg_q          <= reg_rdata;
        end else if (bus.s_axil_rready) begin
            bus.s_axil_rvalid <= 1'b0;
        end
    end

    // NOTE: the sample RAM has no reset so it maps onto block RAM; rd_sel_data masks its power-up contents.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{wbank, wr_idx}] <= bus.s_axis_tdata;
        if (ar_hs)
            mem_q <= mem[{rbank, bus.s_axil_araddr[IDX_W+1:2]}];
    end

    assign bus.s_axil_rdata = rd_sel_data ? 32'(mem_q) : rd_reg_q;

    logic unused_bits;
    assign unused_bits = ^{bus.s_axil_wstrb, bus.s_axil_wdata[31:3],
                           bus.s_axil_awaddr[1:0], bus.s_axil_araddr[1:0]};
endmodule
